// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external data-memory bus initiator:
// FSM state encoding, read issue depth and idle-bus drive levels.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    CAP
  } state_t;

  // The memory read pipeline only advances on read-select cycles, so every read is selected twice.
  localparam int RD_ISSUE_CYCLES = 2;

  localparam logic BUS_IDLE_CSLT = 1'b0;
  localparam logic BUS_IDLE_WRB  = 1'b0;
  localparam logic BUS_IDLE_BIT  = 1'b0;

endpackage

// File: rtl/ext_mem_initiator.sv
// Bus master for the external data memory: valid/ready request channel in,
// registered memory bus out, double-issued reads with a held read response.
module ext_mem_initiator
  import ext_mem_pkg::*;
#(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4,
  parameter int CNT_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [DMA_SIZE-1:0] req_add,
  input  logic [DMD_SIZE-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DMD_SIZE-1:0] rsp_data,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt,
  output logic [CNT_SIZE-1:0] wr_cnt,
  output logic [CNT_SIZE-1:0] rd_cnt
);

  state_t              r_state;
  state_t              w_stateNext;
  logic                r_cslt;
  logic                r_wrb;
  logic [DMA_SIZE-1:0] r_add;
  logic [DMD_SIZE-1:0] r_data;
  logic                r_rspValid;
  logic [DMD_SIZE-1:0] r_rspData;
  logic [CNT_SIZE-1:0] r_wrCnt;
  logic [CNT_SIZE-1:0] r_rdCnt;
  logic                w_accept;
  logic                w_csltNext;
  logic                w_wrbNext;
  logic [DMA_SIZE-1:0] w_addNext;
  logic [DMD_SIZE-1:0] w_dataNext;

  assign req_ready = ((r_state == IDLE) || (r_state == WR)) && !r_rspValid;
  assign w_accept  = req_valid && req_ready;

  // Next state and the bus values for the next cycle; the bus registers double as request capture.
  always_comb begin
    w_stateNext = r_state;
    w_csltNext  = BUS_IDLE_CSLT;
    w_wrbNext   = BUS_IDLE_WRB;
    w_addNext   = {DMA_SIZE{BUS_IDLE_BIT}};
    w_dataNext  = {DMD_SIZE{BUS_IDLE_BIT}};
    case (r_state)
      IDLE, WR: begin
        w_stateNext = IDLE;
        if (w_accept) begin
          w_csltNext = 1'b1;
          w_addNext  = req_add;
          if (req_wr) begin
            w_stateNext = WR;
            w_wrbNext   = 1'b1;
            w_dataNext  = req_data;
          end else begin
            w_stateNext = RD1;
          end
        end
      end
      RD1: begin
        w_stateNext = RD2;
        w_csltNext  = 1'b1;
        w_addNext   = r_add;
      end
      RD2:     w_stateNext = CAP;
      CAP:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Read data is taken only in CAP, when the pipeline holds the twice-issued address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cslt     <= BUS_IDLE_CSLT;
      r_wrb      <= BUS_IDLE_WRB;
      r_add      <= {DMA_SIZE{BUS_IDLE_BIT}};
      r_data     <= {DMD_SIZE{BUS_IDLE_BIT}};
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_wrCnt    <= '0;
      r_rdCnt    <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cslt  <= w_csltNext;
      r_wrb   <= w_wrbNext;
      r_add   <= w_addNext;
      r_data  <= w_dataNext;
      if (r_state == WR) begin
        r_wrCnt <= r_wrCnt + CNT_SIZE'(1);
      end
      if (r_state == CAP) begin
        r_rspData  <= dm_bc_dt;
        r_rspValid <= 1'b1;
        r_rdCnt    <= r_rdCnt + CNT_SIZE'(1);
      end else if (r_rspValid && rsp_ready) begin
        r_rspValid <= 1'b0;
      end
    end
  end

  assign ps_dm_cslt = r_cslt;
  assign ps_dm_wrb  = r_wrb;
  assign dg_dm_add  = r_add;
  assign bc_dt      = r_data;
  assign rsp_valid  = r_rspValid;
  assign rsp_data   = r_rspData;
  assign wr_cnt     = r_wrCnt;
  assign rd_cnt     = r_rdCnt;

endmodule

// File: tb/tb_ext_mem_initiator.sv
// Directed and randomized bench for ext_mem_initiator against a read-counted
// memory model and an address-indexed reference of written data.
module tb_ext_mem_initiator;
  import ext_mem_pkg::*;

  localparam int DMA = 3;
  localparam int DMD = 4;
  localparam int CNT = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           reqValid;
  logic           reqReady;
  logic           reqWr;
  logic [DMA-1:0] reqAdd;
  logic [DMD-1:0] reqData;
  logic           rspValid;
  logic           rspReady;
  logic [DMD-1:0] rspData;
  logic           cslt;
  logic           wrb;
  logic [DMA-1:0] memAdd;
  logic [DMD-1:0] bcDt;
  wire  [DMD-1:0] dmBcDt;
  logic [CNT-1:0] wrCnt;
  logic [CNT-1:0] rdCnt;

  int compareCount = 0;
  int failCount    = 0;
  int wrModel      = 0;
  int rdModel      = 0;
  logic [DMD-1:0] refMem [8];

  logic [DMD-1:0] memArr [8];
  logic [DMD-1:0] memP1;
  logic [DMD-1:0] memOut;
  logic           memDrive;

  ext_mem_initiator #(.DMA_SIZE(DMA), .DMD_SIZE(DMD), .CNT_SIZE(CNT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_wr(reqWr),
    .req_add(reqAdd), .req_data(reqData),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData),
    .ps_dm_cslt(cslt), .ps_dm_wrb(wrb), .dg_dm_add(memAdd), .bc_dt(bcDt),
    .dm_bc_dt(dmBcDt), .wr_cnt(wrCnt), .rd_cnt(rdCnt)
  );

  always #5 clk = ~clk;

  // External memory: writes at the edge, read data moves one stage per read-select cycle.
  always @(posedge clk) begin
    if (cslt && wrb) memArr[memAdd] <= bcDt;
    if (cslt && !wrb) begin
      memP1  <= memArr[memAdd];
      memOut <= memP1;
    end
    memDrive <= cslt && !wrb;
  end
  assign dmBcDt = memDrive ? memOut : 'z;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s check miscompare", tag);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DMA-1:0] a, input logic [DMD-1:0] d);
    int waitCycles = 0;
    reqValid = 1'b1; reqWr = wr; reqAdd = a; reqData = d;
    while (!reqReady && waitCycles < 20) begin
      step();
      waitCycles++;
    end
    if (!reqReady) begin
      checkOutput("acceptTimeout", {31'b0, reqReady}, 32'd1);
      reqValid = 1'b0;
      return;
    end
    step();
    reqValid = 1'b0;
    reqWr    = 1'($urandom);
    reqAdd   = DMA'($urandom);
    reqData  = DMD'($urandom);
    if (wr) begin
      refMem[a] = d;
      wrModel++;
    end
  endtask

  task automatic waitResponse(input string tag, input logic [DMD-1:0] expData, input int hold);
    int waitCycles = 0;
    rspReady = 1'b0;
    while (!rspValid && waitCycles < 20) begin
      step();
      waitCycles++;
    end
    checkOutput({tag, "Valid"}, {31'b0, rspValid}, 32'd1);
    checkOutput({tag, "Data"}, {28'b0, rspData}, {28'b0, expData});
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput({tag, "HoldValid"}, {31'b0, rspValid}, 32'd1);
      checkOutput({tag, "HoldData"}, {28'b0, rspData}, {28'b0, expData});
      checkOutput({tag, "HoldReady"}, {31'b0, reqReady}, 32'd0);
      checkOutput({tag, "HoldBus"}, {31'b0, cslt}, 32'd0);
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    rdModel++;
    checkOutput({tag, "Clear"}, {31'b0, rspValid}, 32'd0);
    checkOutput({tag, "ReadyBack"}, {31'b0, reqReady}, 32'd1);
  endtask

  logic [DMA-1:0] streamAdd  [3];
  logic [DMD-1:0] streamData [3];

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWr = 1'b0; reqAdd = '0; reqData = '0; rspReady = 1'b0;
    streamAdd[0] = 3'd1; streamAdd[1] = 3'd2; streamAdd[2] = 3'd3;
    streamData[0] = 4'h3; streamData[1] = 4'h7; streamData[2] = 4'hF;

    repeat (3) step();
    checkOutput("rstCslt", {31'b0, cslt}, 32'd0);
    checkOutput("rstWrb", {31'b0, wrb}, 32'd0);
    checkOutput("rstAdd", {29'b0, memAdd}, 32'd0);
    checkOutput("rstBcDt", {28'b0, bcDt}, 32'd0);
    checkOutput("rstRspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("rstRspData", {28'b0, rspData}, 32'd0);
    checkOutput("rstWrCnt", {24'b0, wrCnt}, 32'd0);
    checkOutput("rstRdCnt", {24'b0, rdCnt}, 32'd0);
    reset = 1'b0;
    step();
    checkOutput("rstReqReady", {31'b0, reqReady}, 32'd1);

    $display("[TB] single write");
    applyStimulus(1'b1, 3'd5, 4'd9);
    checkOutput("wrCslt", {31'b0, cslt}, 32'd1);
    checkOutput("wrWrb", {31'b0, wrb}, 32'd1);
    checkOutput("wrAdd", {29'b0, memAdd}, 32'd5);
    checkOutput("wrBcDt", {28'b0, bcDt}, 32'd9);
    step();
    checkOutput("wrIdleBus", {31'b0, cslt}, 32'd0);
    checkOutput("wrCnt1", {24'b0, wrCnt}, 32'd1);

    $display("[TB] read back with latency check");
    applyStimulus(1'b0, 3'd5, 4'd0);
    for (int i = 0; i < RD_ISSUE_CYCLES; i++) begin
      checkOutput("rdSelCslt", {31'b0, cslt}, 32'd1);
      checkOutput("rdSelWrb", {31'b0, wrb}, 32'd0);
      checkOutput("rdSelAdd", {29'b0, memAdd}, 32'd5);
      checkOutput("rdSelReady", {31'b0, reqReady}, 32'd0);
      step();
    end
    checkOutput("rdCapCslt", {31'b0, cslt}, 32'd0);
    checkOutput("rdCapValid", {31'b0, rspValid}, 32'd0);
    checkOutput("rdCapReady", {31'b0, reqReady}, 32'd0);
    step();
    checkOutput("rdLatValid", {31'b0, rspValid}, 32'd1);
    checkOutput("rdCnt1", {24'b0, rdCnt}, 32'd1);
    waitResponse("readBack", refMem[5], 0);

    $display("[TB] streaming writes");
    reqValid = 1'b1; reqWr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reqAdd = streamAdd[i]; reqData = streamData[i];
      checkOutput("strmReady", {31'b0, reqReady}, 32'd1);
      step();
      refMem[streamAdd[i]] = streamData[i];
      wrModel++;
      if (i == 2) reqValid = 1'b0;
      checkOutput("strmCslt", {31'b0, cslt}, 32'd1);
      checkOutput("strmWrb", {31'b0, wrb}, 32'd1);
      checkOutput("strmAdd", {29'b0, memAdd}, {29'b0, streamAdd[i]});
      checkOutput("strmBcDt", {28'b0, bcDt}, {28'b0, streamData[i]});
    end
    step();
    checkOutput("strmIdle", {31'b0, cslt}, 32'd0);
    checkOutput("strmWrCnt", {24'b0, wrCnt}, 32'(wrModel % 256));
    applyStimulus(1'b0, 3'd2, 4'd0);
    waitResponse("strmRead2", 4'h7, 0);
    applyStimulus(1'b0, 3'd1, 4'd0);
    waitResponse("strmRead1", 4'h3, 0);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 3'd2, 4'd0);
    waitResponse("backpr", 4'h7, 5);
    checkOutput("backprRdCnt", {24'b0, rdCnt}, 32'(rdModel % 256));

    $display("[TB] reset during second read select");
    applyStimulus(1'b0, 3'd3, 4'd0);
    step();
    checkOutput("midRd2Cslt", {31'b0, cslt}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wrModel = 0; rdModel = 0;
    checkOutput("midRstCslt", {31'b0, cslt}, 32'd0);
    checkOutput("midRstValid", {31'b0, rspValid}, 32'd0);
    checkOutput("midRstWrCnt", {24'b0, wrCnt}, 32'd0);
    checkOutput("midRstRdCnt", {24'b0, rdCnt}, 32'd0);
    applyStimulus(1'b1, 3'd3, 4'hA);
    applyStimulus(1'b0, 3'd3, 4'd0);
    waitResponse("postRst", 4'hA, 0);

    $display("[TB] write counter wrap");
    reqValid = 1'b1; reqWr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      reqAdd = DMA'(i % 8); reqData = DMD'($urandom);
      checkOutput("wrapReady", {31'b0, reqReady}, 32'd1);
      refMem[reqAdd] = reqData;
      step();
      wrModel++;
      checkOutput("wrapBus", {31'b0, cslt}, 32'd1);
    end
    reqValid = 1'b0;
    step();
    checkOutput("wrapWrCnt", {24'b0, wrCnt}, 32'(wrModel % 256));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      logic           rndWr;
      logic [DMA-1:0] rndAdd;
      logic [DMD-1:0] rndData;
      logic [DMD-1:0] expData;
      rndWr   = 1'($urandom_range(0, 1));
      rndAdd  = DMA'($urandom_range(0, 7));
      rndData = DMD'($urandom_range(0, 15));
      expData = refMem[rndAdd];
      repeat ($urandom_range(0, 2)) step();
      applyStimulus(rndWr, rndAdd, rndData);
      if (!rndWr) waitResponse("rand", expData, $urandom_range(0, 3));
    end
    step();
    checkOutput("randWrCnt", {24'b0, wrCnt}, 32'(wrModel % 256));
    checkOutput("randRdCnt", {24'b0, rdCnt}, 32'(rdModel % 256));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
